// File: rtl/frame_config_pkg.sv
// Shared types and constants for the configuration frame sequencer.
package frame_config_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StData,
    StDrain,
    StStrobe
  } state_e;

  localparam logic [31:0] SyncWordDefault = 32'hFAB0_FAB1;

  // Header field positions
  localparam int unsigned HdrEndBit = 31;
  localparam int unsigned HdrColLsb = 0;

endpackage

// File: rtl/frame_config_sequencer_if.sv
// Word stream from the bitstream source and the row/column load bus to the fabric.
interface frame_config_sequencer_if #(
  parameter int unsigned FrameBitsPerRow   = 32,
  parameter int unsigned RowSelectWidth    = 5,
  parameter int unsigned ColumnSelectWidth = 5
);

  logic [FrameBitsPerRow-1:0]   WriteData;
  logic                         WriteValid;
  logic                         WriteReady;
  logic [FrameBitsPerRow-1:0]   FrameData;
  logic [RowSelectWidth-1:0]    RowSelect;
  logic [ColumnSelectWidth-1:0] ColumnSelect;
  logic                         FrameStrobe;

  modport master (
    output WriteData,
    output WriteValid,
    input  WriteReady,
    input  FrameData,
    input  RowSelect,
    input  ColumnSelect,
    input  FrameStrobe
  );

  modport slave (
    input  WriteData,
    input  WriteValid,
    output WriteReady,
    output FrameData,
    output RowSelect,
    output ColumnSelect,
    output FrameStrobe
  );

endinterface

// File: rtl/frame_config_sequencer.sv
// Hunts for the sync word, then loads NumberOfRows row words per header and strobes
// the addressed column.
module frame_config_sequencer
  import frame_config_pkg::*;
#(
  parameter int unsigned          FrameBitsPerRow   = 32,
  parameter int unsigned          RowSelectWidth    = 5,
  parameter int unsigned          NumberOfRows      = 16,
  parameter int unsigned          ColumnSelectWidth = 5,
  parameter int unsigned          NumberOfColumns   = 16,
  parameter logic [FrameBitsPerRow-1:0] SyncWord    = SyncWordDefault
) (
  input  logic                      CLK,
  input  logic                      reset,
  frame_config_sequencer_if.slave   bus,
  output logic                      Busy,
  output logic                      Error
);

  state_e state_q, state_d;

  logic [RowSelectWidth-1:0]    row_cnt_q;
  logic [RowSelectWidth-1:0]    row_sel_q;
  logic [ColumnSelectWidth-1:0] col_q;
  logic [FrameBitsPerRow-1:0]   frame_data_q;
  logic                         strobe_q;
  logic                         busy_q;
  logic                         error_q;

  logic                         write_ready;
  logic                         accept;
  logic                         hdr_end;
  logic                         hdr_col_ok;
  logic                         last_row;
  logic [ColumnSelectWidth-1:0] hdr_col;

  assign accept     = bus.WriteValid && write_ready;
  assign hdr_end    = bus.WriteData[HdrEndBit];
  assign hdr_col    = bus.WriteData[HdrColLsb +: ColumnSelectWidth];
  assign hdr_col_ok = 32'(hdr_col) < NumberOfColumns;
  assign last_row   = row_cnt_q == RowSelectWidth'(NumberOfRows);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && bus.WriteData == SyncWord) state_d = StHeader;
      end
      StHeader: begin
        if (accept) begin
          if (!hdr_end && hdr_col_ok) state_d = StData;
          else                        state_d = StIdle;
        end
      end
      StData: begin
        if (accept && last_row) state_d = StDrain;
      end
      StDrain:  state_d = StStrobe;
      StStrobe: state_d = StHeader;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    write_ready = 1'b0;
    unique case (state_q)
      StIdle, StHeader, StData: write_ready = 1'b1;
      default:                  write_ready = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      row_cnt_q    <= '0;
      row_sel_q    <= '0;
      col_q        <= '0;
      frame_data_q <= '0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      row_sel_q <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= state_d != StIdle;
      if (state_q == StHeader && accept && !hdr_end) begin
        if (hdr_col_ok) begin
          col_q     <= hdr_col;
          row_cnt_q <= RowSelectWidth'(1);
        end else begin
          error_q <= 1'b1;
        end
      end
      if (state_q == StData && accept) begin
        frame_data_q <= bus.WriteData;
        row_sel_q    <= row_cnt_q;
        row_cnt_q    <= row_cnt_q + RowSelectWidth'(1);
      end
      // Strobe lands one cycle after the drain so the last row has been captured.
      if (state_q == StDrain) strobe_q <= 1'b1;
    end
  end

  assign bus.WriteReady   = write_ready;
  assign bus.FrameData    = frame_data_q;
  assign bus.RowSelect    = row_sel_q;
  assign bus.ColumnSelect = col_q;
  assign bus.FrameStrobe  = strobe_q;
  assign Busy             = busy_q;
  assign Error            = error_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Random and directed sessions checked every cycle against a word-level session model.
module tb_frame_config_sequencer;

  localparam int unsigned NumRows = 16;
  localparam int unsigned NumCols = 16;
  localparam logic [31:0] Sync    = 32'hFAB0_FAB1;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic Busy;
  logic Error;

  frame_config_sequencer_if bus_if ();

  frame_config_sequencer dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus_if),
    .Busy  (Busy),
    .Error (Error)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Session model: in_session, rows still owed by the current frame, stall cycles left.
  bit          m_session;
  int          m_rows_left;
  int          m_stall;
  logic [31:0] m_col;
  logic [31:0] m_last_data;
  int          m_row;
  bit          m_strobe;
  bit          m_err;
  bit          m_acc;
  bit          chk_en = 1'b0;
  logic [31:0] w;

  always @(posedge CLK) begin
    if (reset) begin
      m_session = 0; m_rows_left = 0; m_stall = 0; m_col = 0; m_last_data = 0;
      m_row = 0; m_strobe = 0; m_err = 0; m_acc = 0;
    end else begin
      m_acc    = bus_if.WriteValid && (m_stall == 0);
      m_row    = 0;
      m_strobe = 0;
      w        = bus_if.WriteData;
      if (m_stall > 0) begin
        if (m_stall == 2) m_strobe = 1;
        m_stall--;
      end else if (m_acc) begin
        if (!m_session) begin
          m_session = (w == Sync);
        end else if (m_rows_left == 0) begin
          if (w[31]) begin
            m_session = 0;
          end else if ((w % 32) < NumCols) begin
            m_col       = w % 32;
            m_rows_left = NumRows;
          end else begin
            m_err     = 1;
            m_session = 0;
          end
        end else begin
          m_row       = NumRows - m_rows_left + 1;
          m_last_data = w;
          m_rows_left--;
          if (m_rows_left == 0) m_stall = 2;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check_eq("ready",  32'(bus_if.WriteReady), 32'(m_stall == 0));
      check_eq("row",    32'(bus_if.RowSelect), 32'(m_row));
      check_eq("data",   bus_if.FrameData, m_last_data);
      check_eq("strobe", 32'(bus_if.FrameStrobe), 32'(m_strobe));
      check_eq("busy",   32'(Busy), 32'(m_session));
      check_eq("error",  32'(Error), 32'(m_err));
      if (m_strobe) check_eq("column", 32'(bus_if.ColumnSelect), m_col);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      bus_if.WriteValid = 1'b0;
      bus_if.WriteData  = $urandom;
      @(posedge CLK); #1;
    end
  endtask

  task automatic send(input logic [31:0] word, input int max_gap);
    idle(max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0);
    bus_if.WriteValid = 1'b1;
    bus_if.WriteData  = word;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      if (m_acc) break;
    end
    check_eq("accept_timeout", 32'(m_acc), 32'd1);
    bus_if.WriteValid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] hdr, input int max_gap);
    send(hdr, max_gap);
    for (int i = 0; i < int'(NumRows); i++) begin
      send(($urandom_range(0, 9) == 0) ? Sync : $urandom, max_gap);
    end
  endtask

  initial begin
    int sel;
    bus_if.WriteValid = 1'b0;
    bus_if.WriteData  = '0;
    @(posedge CLK); #1;
    chk_en = 1'b1;
    @(negedge CLK);
    check_eq("rst_ready",  32'(bus_if.WriteReady), 32'd1);
    check_eq("rst_row",    32'(bus_if.RowSelect), 32'd0);
    check_eq("rst_strobe", 32'(bus_if.FrameStrobe), 32'd0);
    check_eq("rst_col",    32'(bus_if.ColumnSelect), 32'd0);
    check_eq("rst_data",   bus_if.FrameData, 32'd0);
    check_eq("rst_busy",   32'(Busy), 32'd0);
    check_eq("rst_error",  32'(Error), 32'd0);
    @(posedge CLK); #1;
    reset = 1'b0;

    // Garbage in IDLE is discarded, then a straight frame to column 3.
    for (int i = 0; i < 3; i++) begin
      send(32'hDEAD_BEEF, 0);
      @(negedge CLK);
      check_eq("garbage_busy", 32'(Busy), 32'd0);
    end
    send(Sync, 0);
    @(negedge CLK);
    check_eq("sync_busy", 32'(Busy), 32'd1);
    send(32'h0000_0003, 0);
    for (int i = 0; i < int'(NumRows); i++) send(32'h1000_0000 + i, 0);
    @(negedge CLK);
    check_eq("last_row", 32'(bus_if.RowSelect), 32'd16);
    @(negedge CLK);
    check_eq("strobe_t2", 32'(bus_if.FrameStrobe), 32'd1);
    check_eq("strobe_col", 32'(bus_if.ColumnSelect), 32'd3);
    check_eq("strobe_err", 32'(Error), 32'd0);

    // End of session, then a data-like word is discarded.
    send(32'h8000_0000, 0);
    @(negedge CLK);
    check_eq("end_busy", 32'(Busy), 32'd0);
    send(32'h0000_0002, 0);
    @(negedge CLK);
    check_eq("post_end_busy", 32'(Busy), 32'd0);

    // Out-of-range column sets the sticky error.
    send(Sync, 0);
    send(32'h0000_0010, 0);
    @(negedge CLK);
    check_eq("badcol_err", 32'(Error), 32'd1);
    check_eq("badcol_busy", 32'(Busy), 32'd0);
    send(Sync, 1);
    send_frame(32'h0000_0005, 3);
    idle(4);
    check_eq("err_sticky", 32'(Error), 32'd1);

    // Reset after row 7 abandons the frame; later words need a fresh sync.
    send(32'h0000_0007, 2);
    for (int i = 0; i < 7; i++) send($urandom, 2);
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    @(negedge CLK);
    check_eq("midrst_row", 32'(bus_if.RowSelect), 32'd0);
    check_eq("midrst_strobe", 32'(bus_if.FrameStrobe), 32'd0);
    check_eq("midrst_busy", 32'(Busy), 32'd0);
    for (int i = 0; i < 10; i++) send($urandom, 1);
    @(negedge CLK);
    check_eq("nosync_busy", 32'(Busy), 32'd0);

    // Random sessions with bubbles, bad headers and session ends.
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 3) == 0) send($urandom, 2);
      send(Sync, 2);
      for (int f = 0; f < 4; f++) begin
        sel = int'($urandom_range(0, 99));
        if (sel < 8) begin
          send(32'h8000_0000 | $urandom, 2);
          break;
        end else if (sel < 15) begin
          send(32'(($urandom & 32'h7FFF_FFE0) | $urandom_range(16, 31)), 2);
          break;
        end else begin
          send_frame(32'(($urandom & 32'h7FFF_FFE0) | $urandom_range(0, 15)), 2);
        end
      end
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_config_sequencer.md
# frame_config_sequencer

Sequences configuration loading into the fabric's per-row frame data registers. It accepts a stream of 32-bit configuration words over a valid/ready handshake and hunts for a sync word. It then loads one word per row by driving FrameData with a one-hot-by-value RowSelect, and finally pulses FrameStrobe with a column index so the addressed column latches the assembled frame. It sits between the bitstream source (UART/SPI/internal loader) and the row-level Frame_Data_Reg instances plus the column frame-strobe decode.

## Interface
Parameters:
- FrameBitsPerRow, 32: width of one configuration word and of FrameData.
- RowSelectWidth, 5: width of RowSelect. Rows are addressed 1..NumberOfRows; 0 means no row.
- NumberOfRows, 16: data words per frame. Must be ≤ 2^RowSelectWidth−1.
- ColumnSelectWidth, 5: width of ColumnSelect.
- NumberOfColumns, 16: valid column indices are 0..NumberOfColumns−1.
- SyncWord, 32'hFAB0_FAB1: word that starts a configuration session.

Ports:
- CLK, in, 1: single clock. All logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- WriteData, in, 32: configuration word.
- WriteValid, in, 1: WriteData is valid.
- WriteReady, out, 1: sequencer accepts a word this cycle. A transfer occurs when WriteValid && WriteReady.
- FrameData, out, FrameBitsPerRow: data to the row registers.
- RowSelect, out, RowSelectWidth: target row. Nonzero for exactly one cycle per data word.
- ColumnSelect, out, ColumnSelectWidth: column index. Qualified by FrameStrobe.
- FrameStrobe, out, 1: one-cycle pulse that commits the frame to the column.
- Busy, out, 1: high whenever state ≠ IDLE.
- Error, out, 1: sticky. Cleared only by reset.

## Operation
- States:
  - IDLE: hunt for the sync word.
  - HEADER: wait for a frame header.
  - DATA: load row words.
  - DRAIN: let the last row word settle.
  - STROBE: pulse FrameStrobe.
- IDLE: WriteReady=1. Words other than SyncWord are consumed and discarded. Accepting SyncWord moves to HEADER.
- HEADER: WriteReady=1. An accepted word is decoded as follows:
  - bit 31 = 1: end of session. Go to IDLE and do not modify Error.
  - bit 31 = 0 and bits[ColumnSelectWidth-1:0] < NumberOfColumns: latch the column index, set row counter to 1, go to DATA.
  - otherwise (column out of range): set Error, go to IDLE. No strobe is issued.
- DATA: WriteReady=1. Each accepted word is registered to FrameData, with RowSelect = row counter on the next cycle. The counter then increments. Accepting word NumberOfRows moves to DRAIN.
  - Data words are opaque; SyncWord inside DATA is treated as data.
- DRAIN: WriteReady=0. One cycle, then STROBE.
- STROBE: WriteReady=0. FrameStrobe=1 and ColumnSelect = latched column for one cycle, then HEADER.
- In cycles with no accepted data word, RowSelect=0 and FrameData holds its last value.

## Timing
- All outputs are registered except WriteReady, which is decoded from state.
- Reset values: state IDLE, FrameData=0, RowSelect=0, ColumnSelect=0, FrameStrobe=0, Busy=0, Error=0. WriteReady=1 (IDLE).
- Data word accepted at edge t: FrameData/RowSelect are valid during cycle t+1. The row register captures at the end of t+1.
- Last data word accepted at edge t:
  - t+1: RowSelect=NumberOfRows (DRAIN).
  - t+2: FrameStrobe=1 (STROBE).
  - t+3: HEADER, WriteReady=1.
- Minimum frame cost: 1 header + NumberOfRows data cycles + 2 stall cycles.
- Back-to-back words at WriteValid=1 are accepted every cycle in IDLE, HEADER and DATA. WriteValid low inserts bubbles; no state change occurs without a transfer.
- Reset asserted mid-frame: on the next edge all outputs take reset values and any partial frame is abandoned. No FrameStrobe is issued.
- Row counter is RowSelectWidth bits wide. The transition at NumberOfRows is the only terminating condition; the counter never wraps.

## Structure
- Shared package frame_config_pkg holds:
  - the state enum (IDLE, HEADER, DATA, DRAIN, STROBE);
  - the SyncWord default;
  - header field constants: end-of-session bit = 31, column field LSB = 0.
- No sub-module. It is a single FSM with a row counter and output registers. Frame_Data_Reg instances and the column strobe decode are instantiated at fabric top level.

## Test plan
- Reset, then SyncWord, header 0x0000_0003, 16 words 0x1000_0000+i: RowSelect steps 1..16 one cycle after each accept. FrameStrobe=1 with ColumnSelect=3 exactly 2 cycles after the 16th accept. Error=0.
- Garbage 0xDEAD_BEEF ×3 in IDLE, then SyncWord: garbage is discarded with Busy=0, and Busy=1 after the sync is accepted.
- Header 0x0000_0010 with NumberOfColumns=16: Error=1, state IDLE, no FrameStrobe. Error stays 1 after a subsequent valid session.
- Random WriteValid gaps during DATA: RowSelect is nonzero only on cycles following accepts, and no row index is skipped or repeated. WriteReady=0 during DRAIN/STROBE, and words held then are accepted afterward.
- Reset asserted after row 7 of a frame: next cycle RowSelect=0, FrameStrobe=0, Busy=0. A new SyncWord is required before any load.
- Header 0x8000_0000 after a completed frame: returns to IDLE with Busy=0. A following data-like word is discarded.
